// File: rtl/lc_transition_sequencer.sv
// lc_transition_sequencer: loads transition/auth IDs, drives the MCSE lifecycle handshake; define LC_ID_ZEROIZE_EN to wipe IDs after each sequence
module lc_transition_sequencer #(
  parameter int WORD_W = 32,
  parameter int ID_W = 256,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic              host_wr_sel,
  input  logic [WORD_W-1:0] host_wr_data,
  input  logic              host_go,
  input  logic              host_abort,
  output logic [ID_W-1:0]   lc_transition_id,
  output logic              lc_transition_request_in,
  input  logic              lc_authentication_request,
  output logic [ID_W-1:0]   lc_authentication_id,
  output logic              lc_authentication_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        status_code
);
  localparam int NWORDS = ID_W / WORD_W;
  localparam int PW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_AUTH, AUTH, DONE} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] auth_reg;
  logic [PW-1:0] tcnt, acnt;
  logic [TW-1:0] tmr;
  logic loaded_t, loaded_a, wr, go_ok, go_bad, abort, tout, zap, err_n;
  logic [1:0] status_n;
  always_comb begin
    wr = host_wr_valid & (state == IDLE);
    go_ok = (state == IDLE) & host_go & ~host_wr_valid & loaded_t & loaded_a;
    go_bad = (state == IDLE) & host_go & ~host_wr_valid & ~(loaded_t & loaded_a);
    abort = host_abort & (state == REQ || state == WAIT_AUTH || state == AUTH);
    tout = (state == WAIT_AUTH) & ~lc_authentication_request & (tmr == TW'(TIMEOUT_CYCLES - 1));
`ifdef LC_ID_ZEROIZE_EN
    zap = abort | tout | (state == DONE);
`else
    zap = 1'b0;
`endif
    err_n = go_bad | tout | abort;
    status_n = abort ? 2'd3 : tout ? 2'd2 : go_bad ? 2'd1 : (wr | go_ok) ? 2'd0 : status_code;
    state_n = state;
    case (state)
      IDLE:      state_n = go_ok ? REQ : IDLE;
      REQ:       state_n = WAIT_AUTH;
      WAIT_AUTH: state_n = lc_authentication_request ? AUTH : tout ? IDLE : WAIT_AUTH;
      AUTH:      state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      host_wr_ready <= 1'b1;
      busy <= 1'b0;
      lc_transition_request_in <= 1'b0;
      lc_authentication_valid <= 1'b0;
      lc_authentication_id <= '0;
      done <= 1'b0;
      error <= 1'b0;
      status_code <= 2'd0;
    end else begin
      state <= state_n;
      tmr <= (state == REQ) ? '0 : (state == WAIT_AUTH) ? tmr + TW'(1) : tmr;
      host_wr_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      lc_transition_request_in <= state_n == REQ;
      lc_authentication_valid <= state_n == AUTH;
      lc_authentication_id <= (state_n == AUTH) ? auth_reg : '0;
      done <= state_n == DONE;
      error <= err_n;
      status_code <= status_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || zap) begin
      lc_transition_id <= '0;
      auth_reg <= '0;
      tcnt <= '0;
      acnt <= '0;
      loaded_t <= 1'b0;
      loaded_a <= 1'b0;
    end else if (wr && !host_wr_sel) begin
      lc_transition_id[tcnt*WORD_W +: WORD_W] <= host_wr_data;
      tcnt <= (tcnt == PW'(NWORDS - 1)) ? '0 : tcnt + PW'(1);
      loaded_t <= loaded_t | (tcnt == PW'(NWORDS - 1));
    end else if (wr) begin
      auth_reg[acnt*WORD_W +: WORD_W] <= host_wr_data;
      acnt <= (acnt == PW'(NWORDS - 1)) ? '0 : acnt + PW'(1);
      loaded_a <= loaded_a | (acnt == PW'(NWORDS - 1));
    end
  end
endmodule

// File: tb/tb_lc_transition_sequencer.sv
// tb_lc_transition_sequencer: directed and random sequences checked against a word-array reference model
module tb_lc_transition_sequencer;
  localparam int W = 32, IW = 256, N = 8, T = 16;
`ifdef LC_ID_ZEROIZE_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, host_wr_valid = 1'b0, host_wr_sel = 1'b0, host_go = 1'b0;
  logic host_abort = 1'b0, lc_authentication_request = 1'b0;
  logic [W-1:0] host_wr_data = '0;
  logic host_wr_ready, lc_transition_request_in, lc_authentication_valid, busy, done, error;
  logic [IW-1:0] lc_transition_id, lc_authentication_id;
  logic [1:0] status_code;
  int total = 0, passed = 0, failed = 0;
  logic [W-1:0] mw [2][N];
  int mc [2];
  bit ml [2];
  logic [1:0] mst;
  always #5 clk = ~clk;
  lc_transition_sequencer #(.WORD_W(W), .ID_W(IW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_sel(host_wr_sel),
    .host_wr_data(host_wr_data), .host_go(host_go), .host_abort(host_abort),
    .lc_transition_id(lc_transition_id), .lc_transition_request_in(lc_transition_request_in),
    .lc_authentication_request(lc_authentication_request), .lc_authentication_id(lc_authentication_id),
    .lc_authentication_valid(lc_authentication_valid), .busy(busy), .done(done), .error(error),
    .status_code(status_code)
  );
  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [IW-1:0] id_of(input int s);
    logic [IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = mw[s][i];
    return r;
  endfunction
  task automatic mclear;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) mw[s][i] = '0;
      mc[s] = 0;
      ml[s] = 1'b0;
    end
  endtask
  task automatic mwrite(input int s, input logic [W-1:0] d);
    mw[s][mc[s]] = d;
    mc[s] = (mc[s] + 1) % N;
    if (mc[s] == 0) ml[s] = 1'b1;
    mst = 2'd0;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, host_wr_ready, 1'b1);
    chk({tag, "_status"}, status_code, mst);
    chk({tag, "_tid"}, lc_transition_id, id_of(0));
    chk({tag, "_aid"}, lc_authentication_id, '0);
    chk({tag, "_valid"}, lc_authentication_valid, 1'b0);
    chk({tag, "_req"}, lc_transition_request_in, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask
  task automatic wr(input int s, input logic [W-1:0] d);
    chk("wr_ready", host_wr_ready, 1'b1);
    host_wr_valid = 1'b1;
    host_wr_sel = s[0];
    host_wr_data = d;
    tick;
    host_wr_valid = 1'b0;
    mwrite(s, d);
    chk("wr_status", status_code, mst);
    chk("wr_tid", lc_transition_id, id_of(0));
  endtask
  task automatic reload;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) wr(s, $urandom);
  endtask
  task automatic seq(input int lat, input int ab, input bit rst_auth);
    int lim, fin, kind;
    host_go = 1'b1;
    tick;
    host_go = 1'b0;
    if (!(ml[0] && ml[1])) begin
      mst = 2'd1;
      chk("nl_error", error, 1'b1);
      chk("nl_req", lc_transition_request_in, 1'b0);
      chk("nl_busy", busy, 1'b0);
      chk("nl_status", status_code, mst);
      tick;
      chk("nl_error_clr", error, 1'b0);
      return;
    end
    mst = 2'd0;
    chk("req_pulse", lc_transition_request_in, 1'b1);
    chk("req_busy", busy, 1'b1);
    chk("req_ready", host_wr_ready, 1'b0);
    chk("req_tid", lc_transition_id, id_of(0));
    tick;
    chk("req_once", lc_transition_request_in, 1'b0);
    chk("wait_busy", busy, 1'b1);
    lim = (lat >= 0 && lat < T) ? lat : T - 1;
    fin = (ab >= 0 && ab <= lim) ? ab : lim;
    kind = (ab >= 0 && ab <= lim) ? 3 : (lat >= 0 && lat < T) ? 0 : 2;
    for (int k = 0; k <= fin; k++) begin
      host_abort = (k == ab);
      lc_authentication_request = (lat >= 0 && k >= lat);
      tick;
      if (k < fin) begin
        chk("wait_valid", lc_authentication_valid, 1'b0);
        chk("wait_busy_k", busy, 1'b1);
      end
    end
    host_abort = 1'b0;
    lc_authentication_request = 1'b0;
    if (kind == 0) begin
      chk("auth_valid", lc_authentication_valid, 1'b1);
      chk("auth_id", lc_authentication_id, id_of(1));
      chk("auth_tid", lc_transition_id, id_of(0));
      chk("auth_busy", busy, 1'b1);
      if (rst_auth) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mclear;
        mst = 2'd0;
        idle_chk("rst_auth");
        chk("rst_auth_err", error, 1'b0);
        return;
      end
      tick;
      chk("done_pulse", done, 1'b1);
      chk("done_valid", lc_authentication_valid, 1'b0);
      chk("done_aid", lc_authentication_id, '0);
      if (ZERO) mclear;
      tick;
      idle_chk("after_done");
      chk("after_done_err", error, 1'b0);
    end else begin
      mst = kind[1:0];
      chk("term_error", error, 1'b1);
      chk("term_valid", lc_authentication_valid, 1'b0);
      if (ZERO) mclear;
      idle_chk("term");
      tick;
      chk("term_error_clr", error, 1'b0);
    end
  endtask
  initial begin
    mclear;
    mst = 2'd0;
    tick;
    tick;
    idle_chk("reset_hold");
    rst = 1'b0;
    tick;
    idle_chk("reset");
    chk("reset_err", error, 1'b0);
    host_abort = 1'b1;
    tick;
    host_abort = 1'b0;
    idle_chk("idle_abort");
    chk("idle_abort_err", error, 1'b0);
    for (int i = 0; i < 7; i++) wr(0, $urandom);
    for (int i = 0; i < 8; i++) wr(1, $urandom);
    seq(0, -1, 1'b0);
    wr(0, $urandom);
    host_wr_valid = 1'b1;
    host_go = 1'b1;
    host_wr_sel = 1'b1;
    host_wr_data = 32'h1234_5678;
    tick;
    host_wr_valid = 1'b0;
    host_go = 1'b0;
    mwrite(1, 32'h1234_5678);
    chk("wrgo_req", lc_transition_request_in, 1'b0);
    chk("wrgo_busy", busy, 1'b0);
    chk("wrgo_err", error, 1'b0);
    for (int i = 0; i < 8; i++) wr(0, W'(i + 1));
    for (int i = 0; i < 8; i++) wr(1, 32'hA000_0000 + W'(i));
    chk("main_tid", lc_transition_id,
        256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    seq(4, -1, 1'b0);
    reload;
    seq(-1, -1, 1'b0);
    reload;
    seq(3, 3, 1'b0);
    reload;
    seq(T - 1, -1, 1'b0);
    seq(2, -1, 1'b0);
    reload;
    seq(1, -1, 1'b1);
    seq(0, -1, 1'b0);
    for (int it = 0; it < 25; it++) begin
      int n, lat, ab;
      n = int'($urandom_range(0, 20));
      for (int j = 0; j < n; j++) wr(int'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 2) == 0) reload;
      lat = int'($urandom_range(0, 21)) - 1;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 17)) : -1;
      seq(lat, ab, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lc_transition_sequencer.md
Name: lc_transition_sequencer

Overview:
- Host-side sequencer that sits directly upstream of the MCSE top-level lifecycle interface.
- Loads a 256-bit transition ID and a 256-bit authentication ID from a 32-bit host write bus.
- Issues the lifecycle transition request, waits for the MCSE authentication request, then presents the authentication ID with a one-cycle valid.
- Provides timeout, abort and status reporting to the host.

Parameters:
- WORD_W, 32, host write-data width.
- ID_W, 256, width of each ID; must be a multiple of WORD_W (NWORDS = ID_W/WORD_W = 8).
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT_AUTH before timeout error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- host_wr_valid  in  1  host word write strobe.
- host_wr_ready  out  1  high only in IDLE.
- host_wr_sel  in  1  0 = transition ID, 1 = authentication ID.
- host_wr_data  in  WORD_W  write word.
- host_go  in  1  start-sequence pulse.
- host_abort  in  1  abort pulse.
- lc_transition_id  out  ID_W  to MCSE lc_transition_id.
- lc_transition_request_in  out  1  to MCSE, one-cycle pulse.
- lc_authentication_request  in  1  from MCSE, level-sampled.
- lc_authentication_id  out  ID_W  to MCSE; zero except in the AUTH cycle.
- lc_authentication_valid  out  1  to MCSE, one-cycle pulse.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle error pulse.
- status_code  out  2  sticky: 0 OK, 1 NOT_LOADED, 2 TIMEOUT, 3 ABORTED.

Behaviour:
- Reset (rst high at a clk edge): FSM to IDLE.
  - All ID registers, word counters, loaded flags and the timeout counter cleared.
  - All outputs 0, except host_wr_ready = 1.
  - Reset mid-sequence aborts silently: no error pulse, status_code = 0.
- All outputs are registered.
- Load path, IDLE only:
  - host_wr_valid & host_wr_ready writes host_wr_data into word[cnt_sel] of the selected ID. Word 0 occupies bits [WORD_W-1:0].
  - cnt_sel increments; on reaching NWORDS it wraps to 0 and sets loaded_sel.
  - Further writes overwrite from word 0; loaded_sel stays set.
  - Each accepted write clears status_code to 0.
- FSM states: IDLE, REQ, WAIT_AUTH, AUTH, DONE.
- IDLE:
  - host_go with both loaded flags set -> REQ; status_code := 0.
  - host_go with either flag clear -> stay in IDLE; error pulse next cycle; status_code := 1.
  - Writes and go in the same cycle: the write is performed and go is ignored.
- REQ:
  - lc_transition_request_in = 1 for exactly this cycle, so it rises the cycle after go is sampled.
  - Timeout counter := 0. Next state WAIT_AUTH.
- WAIT_AUTH:
  - lc_authentication_request = 1 -> AUTH.
  - Otherwise the counter increments; at count TIMEOUT_CYCLES-1 -> IDLE with error pulse and status_code := 2.
  - Request and timeout in the same cycle: the request wins.
- AUTH:
  - lc_authentication_valid = 1 and lc_authentication_id = auth register, for one cycle only.
  - Next state DONE.
- DONE: done = 1 for one cycle; -> IDLE; status_code stays 0.
- lc_transition_id holds the register value at all times and is stable from REQ through DONE, because writes are blocked outside IDLE.
- host_abort in REQ, WAIT_AUTH or AUTH -> IDLE next cycle, error pulse, status_code := 3.
  - Abort has priority over lc_authentication_request and over timeout in the same cycle.
  - In the abort cycle no valid or request pulse is emitted.
- host_abort in IDLE or DONE is ignored.
- busy = 1 in every non-IDLE state.

Optional Feature:
- Macro: LC_ID_ZEROIZE_EN.
- Defined: on leaving DONE, on timeout and on abort, both ID registers, both word counters and both loaded flags are cleared in the same cycle as the return to IDLE. A retry therefore requires a full reload; go without a reload gives status 1.
- Undefined: registers and flags are retained, so host_go can retry immediately with the same IDs.

Test Plan:
- Load 8 words 0x00000001..0x00000008 with sel=0 and 8 words 0xA0000000..0xA0000007 with sel=1, then go, with the MCSE raising auth_request 5 cycles after the request pulse.
  - lc_transition_id = {0x8,...,0x1}; request pulse 1 cycle after go.
  - valid 1 cycle after auth_request, with auth_id = {0xA0000007,...,0xA0000000}.
  - done the next cycle; status_code = 0.
- Load only 7 transition words plus a full auth ID, then go -> no request pulse; error pulse; status_code = 1; busy stays 0.
- With TIMEOUT_CYCLES = 16, go with auth_request held 0 -> IDLE after 16 WAIT_AUTH cycles; error pulse; status_code = 2; valid never asserted.
- In WAIT_AUTH, assert host_abort and auth_request in the same cycle -> IDLE; status_code = 3; no valid pulse; with LC_ID_ZEROIZE_EN, lc_transition_id = 0.
- Drive auth_request and timeout expiry in the same cycle -> valid pulse, then done; status_code = 0.
- Assert rst in AUTH -> all outputs 0 next cycle, host_wr_ready = 1, status_code = 0; a subsequent go without reload returns status 1.
